// File: rtl/samp_hit_serializer_if.sv
// Batch-in / hit-out stream bundle for samp_hit_serializer.
// The serializer takes the slave view; the upstream/downstream side takes the master view.
interface samp_hit_serializer_if #(
   parameter int SIGFIG = 24,
   parameter int COLORS = 3,
   parameter int SAMPS  = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic [SAMPS-1:0]             in_hit_mask;
   logic [SAMPS*2*SIGFIG-1:0]    in_samp_xy;
   logic [SAMPS*SIGFIG-1:0]      in_samp_z;
   logic [COLORS*SIGFIG-1:0]     in_color;
   logic                         out_valid;
   logic                         out_ready;
   logic [2*SIGFIG-1:0]          out_xy;
   logic [SIGFIG-1:0]            out_z;
   logic [COLORS*SIGFIG-1:0]     out_color;
   logic                         out_last;
   logic [31:0]                  hit_count;

   modport slave (
      input  in_valid, in_hit_mask, in_samp_xy, in_samp_z, in_color, out_ready,
      output in_ready, out_valid, out_xy, out_z, out_color, out_last, hit_count
   );

   modport master (
      output in_valid, in_hit_mask, in_samp_xy, in_samp_z, in_color, out_ready,
      input  in_ready, out_valid, out_xy, out_z, out_color, out_last, hit_count
   );
endinterface

// File: rtl/samp_hit_serializer.sv
// Captures one batch of tested samples and emits the hit samples one per cycle,
// lowest sample index first, with a saturating count of accepted hits.
module samp_hit_serializer #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int COLORS = 3,
   parameter int SAMPS  = 8
) (
   input logic                   clk,
   input logic                   rst,
   samp_hit_serializer_if.slave  bus
);
   localparam int XYW = 2 * SIGFIG;
   localparam int CW  = COLORS * SIGFIG;

   if (RADIX > SIGFIG) begin : g_bad_radix
      $error("RADIX must not exceed SIGFIG");
   end
   if (SAMPS < 1 || SAMPS > 32) begin : g_bad_samps
      $error("SAMPS must be in 1..32");
   end

   logic [SAMPS-1:0]   pend_q;
   logic [XYW-1:0]     xy_q [SAMPS];
   logic [SIGFIG-1:0]  z_q  [SAMPS];
   logic [CW-1:0]      color_q;
   logic [31:0]        hit_cnt_q;

   logic [SAMPS-1:0]   sel_oh;
   logic [SAMPS-1:0]   pend_rest;
   logic [XYW-1:0]     xy_sel;
   logic [SIGFIG-1:0]  z_sel;
   logic               out_valid;
   logic               out_last;
   logic               pop;
   logic               load;

   // Two's-complement trick isolates the lowest pending slot as a one-hot.
   assign sel_oh    = pend_q & (~pend_q + SAMPS'(1));
   assign pend_rest = pend_q & ~sel_oh;
   assign out_valid = |pend_q;
   assign out_last  = out_valid && (pend_rest == '0);
   assign pop       = out_valid && bus.out_ready;
   assign load      = bus.in_valid && bus.in_ready;

   always_comb begin
      xy_sel = '0;
      z_sel  = '0;
      for (int i = 0; i < SAMPS; i++) begin
         if (sel_oh[i]) begin
            xy_sel = xy_sel | xy_q[i];
            z_sel  = z_sel | z_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= '0;
         color_q   <= '0;
         hit_cnt_q <= '0;
         for (int i = 0; i < SAMPS; i++) begin
            xy_q[i] <= '0;
            z_q[i]  <= '0;
         end
      end else begin
         if (pop && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         // A load on the last-hit pop cycle replaces pend outright.
         if (load) begin
            pend_q  <= bus.in_hit_mask;
            color_q <= bus.in_color;
            for (int i = 0; i < SAMPS; i++) begin
               xy_q[i] <= bus.in_samp_xy[i*XYW +: XYW];
               z_q[i]  <= bus.in_samp_z[i*SIGFIG +: SIGFIG];
            end
         end else if (pop) begin
            pend_q <= pend_rest;
         end
      end
   end

   assign bus.in_ready  = !rst && (!out_valid || (out_last && bus.out_ready));
   assign bus.out_valid = out_valid;
   assign bus.out_last  = out_last;
   assign bus.out_xy    = xy_sel;
   assign bus.out_z     = z_sel;
   assign bus.out_color = color_q;
   assign bus.hit_count = hit_cnt_q;
endmodule

// File: doc/samp_hit_serializer.md
# samp_hit_serializer

Sits directly downstream of the sample-test stage. Each cycle that stage can deliver a batch of `SAMPS` tested samples with a per-sample hit mask. This block captures one batch, then emits only the hit samples, one per cycle and in ascending sample-index order, to the z-buffer/shader interface. It applies backpressure upstream while a batch is still draining.

## Interface
- `SIGFIG`, 24, bits per position/depth/color word
- `RADIX`, 10, fraction bits; carried through untouched
- `COLORS`, 3, color channels per triangle
- `SAMPS`, 8, samples per batch; 1..32
- `clk` in 1, single clock
- `rst` in 1, synchronous, active-high reset
- `in_valid` in 1, upstream batch present
- `in_ready` out 1, block can accept a batch this cycle
- `in_hit_mask` in `SAMPS`, bit i is set when sample i is inside the triangle
- `in_samp_xy` in `SAMPS*2*SIGFIG`, per-sample (x,y), fixed point
- `in_samp_z` in `SAMPS*SIGFIG`, per-sample interpolated depth
- `in_color` in `COLORS*SIGFIG`, triangle color (one per batch)
- `out_valid` out 1, hit sample present
- `out_ready` in 1, downstream accepts this cycle
- `out_xy` out `2*SIGFIG`, hit sample position
- `out_z` out `SIGFIG`, hit sample depth
- `out_color` out `COLORS*SIGFIG`, batch color
- `out_last` out 1, this hit is the final hit of its batch
- `hit_count` out 32, total hits accepted downstream; saturates at 2^32-1

## Operation
- **Storage.** One batch register holds xy, z, color and the pending mask `pend[SAMPS-1:0]`. There is no other buffering.
- **States.**
  - EMPTY: `pend==0`.
  - DRAIN: `pend!=0`.
  - State is derived from `pend`; no separate state register is required.
- **Output path.**
  - `out_valid = |pend`.
  - Selected index `s` = lowest set bit of `pend`.
  - `out_xy`, `out_z` come from slot `s`. `out_color` comes from the batch register.
  - `out_last = (pend` with bit `s` cleared`) == 0`.
  - Data outputs are don't-care when `out_valid=0`, but hold their stored values (no X).
- **Pop.** When `out_valid && out_ready`, clear `pend[s]` and increment `hit_count` unless it is saturated.
- **Input handshake.**
  - `in_ready = !rst && (pend==0 || (out_last && out_ready))`.
  - `in_ready` is combinational from `out_ready`. This is intentional: it gives zero-bubble back-to-back batches.
- **Load.**
  - When `in_valid && in_ready`, load all batch fields and set `pend <= in_hit_mask`.
  - If a pop happens in the same cycle, the load wins for `pend`.
- **Zero-hit batch.** Accepted and dropped. `pend` stays 0, nothing is emitted and `in_ready` stays high.
- **Output stability.** While `out_valid && !out_ready`, all `out_*` stay stable. `out_valid` never drops without a pop.
- **Input data.** No arithmetic is performed on sample data; RADIX-format words pass through bit-exact.
- **Reset.**
  - Clears `pend` and `hit_count`, and zeroes the batch register.
  - A reset mid-drain discards the remaining hits.
  - Reset values: `out_valid=0`, `out_last=0`, `out_xy=0`, `out_z=0`, `out_color=0`, `hit_count=0`, `in_ready=0` while `rst=1`.

## Timing
- Accept to first hit: 1 cycle. A batch accepted at edge N drives `out_valid=1` in the cycle after N.
- A batch with k≥1 hits occupies the output for exactly k cycles when `out_ready=1` throughout.
- Sustained throughput: 1 hit/cycle with no bubble between batches. The next batch is accepted on the edge that pops the current batch's last hit.
- `out_ready=0` stalls the drain with no state change, and `in_ready` stays 0 while `pend` has 2 or more bits set.
- `hit_count` updates on the edge of each pop and is visible the next cycle.
- No combinational path exists from `in_*` to `out_*`. There is a combinational path from `out_ready` to `in_ready`.

## Test plan
- **Single batch.** Reset, then send `in_hit_mask=8'b1010_0101` with `out_ready=1`.
  - Hits emerge for slots 0, 2, 5, 7 on 4 consecutive cycles.
  - `out_last=1` only on slot 7.
  - `in_ready=1` during the slot-7 cycle.
  - `hit_count=4` afterwards.
- **Back-to-back full batches.** Two batches with mask `8'hFF`, consecutive, `out_ready=1`.
  - 16 consecutive valid cycles with no bubble.
  - `out_last` asserts on cycles 8 and 16.
  - Second batch data matches its own inputs.
- **Backpressure.** Mask `8'b0001_0010`. Hold `out_ready=0` for 3 cycles after `out_valid` rises, then release.
  - Slot 1 is held stable for 4 cycles, then slot 4 follows.
  - `in_ready` stays 0 until the slot-4 cycle.
- **Zero-hit batch.** Mask `8'h00` followed by mask `8'h80`.
  - The first batch emits nothing and `in_ready` stays 1.
  - Slot 7 appears 1 cycle after the second batch is accepted, with `out_last=1`.
- **Reset mid-drain.** Mask `8'hFF`, pulse `rst` after 3 pops.
  - Next cycle: `out_valid=0` and `hit_count=0`.
  - After reset, a new batch with mask `8'h01` emits only slot 0.
- **Saturation.** Force `hit_count` to 2^32-2, then pop 3 hits.
  - Reads 2^32-1 and holds; no wrap to 0.
